// File: rtl/mips_mc_control.sv
// ============================================================================
// Module   : mips_mc_control
// Purpose  : Multi-cycle MIPS control FSM (lw/sw/R-type/beq/addi/j) with
//            handshaked memory access and sticky illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_control #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_en,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BEQEX  = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JEX    = 4'd11;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [3:0] S_ILLEGAL_NEXT = ILLEGAL_HALT ? S_HALT : S_FETCH;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b111;

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       funct_ok;
    logic [2:0] rt_alu_op;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        rt_alu_op = ALU_ADD;
        case (funct)
            6'b100000: rt_alu_op = ALU_ADD;
            6'b100010: rt_alu_op = ALU_SUB;
            6'b100100: rt_alu_op = ALU_AND;
            6'b100101: rt_alu_op = ALU_OR;
            6'b000000: rt_alu_op = ALU_SLL;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_ILLEGAL_NEXT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEX: begin
                if (funct_ok) begin
                    state_d = S_RTWB;
                end else begin
                    state_d   = S_ILLEGAL_NEXT;
                    illegal_d = 1'b1;
                end
            end
            S_RTWB:   state_d = S_FETCH;
            S_BEQEX:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JEX:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; the FETCH strobes are gated by rst_n so that an
    // asserted reset suppresses them even while mem_ready is high.
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_en      = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready & rst_n;
                pc_en     = mem_ready & rst_n;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = rt_alu_op;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JEX: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal   = illegal_q;
    assign state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_control.sv
// ============================================================================
// Module   : tb_mips_mc_control
// Purpose  : Instruction-level reference model driving two controller
//            instances (ILLEGAL_HALT = 0 and 1) with directed + random programs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_control;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       pc_en;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       mreq_a, mwr_a, iord_a, irw_a, rw_a, pcen_a, rdst_a, m2r_a, asa_a, ill_a;
    logic [1:0] asb_a, pcs_a;
    logic [2:0] aop_a;
    logic [3:0] st_a;
    logic       mreq_b, mwr_b, iord_b, irw_b, rw_b, pcen_b, rdst_b, m2r_b, asa_b, ill_b;
    logic [1:0] asb_b, pcs_b;
    logic [2:0] aop_b;
    logic [3:0] st_b;

    mips_mc_control #(.ILLEGAL_HALT(1'b0)) u_dut_flag (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mreq_a), .mem_write(mwr_a), .iord(iord_a),
        .ir_write(irw_a), .reg_write(rw_a), .pc_en(pcen_a), .reg_dst(rdst_a),
        .mem_to_reg(m2r_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .pc_src(pcs_a),
        .alu_op(aop_a), .illegal(ill_a), .state_dbg(st_a)
    );

    mips_mc_control #(.ILLEGAL_HALT(1'b1)) u_dut_halt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mreq_b), .mem_write(mwr_b), .iord(iord_b),
        .ir_write(irw_b), .reg_write(rw_b), .pc_en(pcen_b), .reg_dst(rdst_b),
        .mem_to_reg(m2r_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .pc_src(pcs_b),
        .alu_op(aop_b), .illegal(ill_b), .state_dbg(st_b)
    );

    exp_t obs_a, obs_b;
    assign obs_a = {st_a, mreq_a, mwr_a, iord_a, irw_a, rw_a, pcen_a, rdst_a, m2r_a,
                    asa_a, asb_a, pcs_a, aop_a, ill_a};
    assign obs_b = {st_b, mreq_b, mwr_b, iord_b, irw_b, rw_b, pcen_b, rdst_b, m2r_b,
                    asa_b, asb_b, pcs_b, aop_b, ill_b};

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    bit   halt_mode = 1'b0;
    logic m_ill = 1'b0;

    // Quiet phase: all enables off, adder selected, sticky flag as modelled.
    function automatic exp_t quiet(input logic [3:0] st);
        exp_t e;
        e        = '0;
        e.st     = st;
        e.alu_op = 3'b010;
        e.ill    = m_ill;
        return e;
    endfunction

    function automatic exp_t fetch_phase(input logic strobe);
        exp_t e;
        e           = quiet(4'd0);
        e.mem_req   = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = strobe;
        e.pc_en     = strobe;
        return e;
    endfunction

    task automatic cmp(input exp_t e, input string tag);
        exp_t o;
        o = halt_mode ? obs_b : obs_a;
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic cyc(input exp_t e, input logic mr, input string tag);
        mem_ready = mr;
        @(negedge clk);
        cmp(e, tag);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic take_illegal(input string tag);
        m_ill = 1'b1;
        if (halt_mode) begin
            for (int i = 0; i < 5; i++) begin
                opcode = 6'($urandom);
                cyc(quiet(4'd15), rbit(), tag);
            end
        end
    endtask

    // One instruction from FETCH back to FETCH. fw/mw are memory wait
    // cycles for the fetch and the data access; abort_mw pulses rst_n
    // asynchronously part-way through a store's wait.
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                         input int fw, input int mw, input bit abort_mw);
        exp_t e;
        logic [2:0] aop;
        bit fok;
        opcode = op;
        funct  = fn;
        zero   = z;
        for (int i = 0; i < fw; i++) cyc(fetch_phase(1'b0), 1'b0, "fetch_wait");
        cyc(fetch_phase(1'b1), 1'b1, "fetch");
        e = quiet(4'd1); e.alu_src_b = 2'b11;
        cyc(e, rbit(), "decode");
        case (op)
            6'b100011, 6'b101011: begin
                e = quiet(4'd2); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cyc(e, rbit(), "memadr");
                if (op == 6'b100011) begin
                    e = quiet(4'd3); e.mem_req = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mw; i++) cyc(e, 1'b0, "memrd_wait");
                    cyc(e, 1'b1, "memrd");
                    e = quiet(4'd4); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                    cyc(e, rbit(), "memwb");
                end else begin
                    e = quiet(4'd5); e.mem_req = 1'b1; e.mem_write = 1'b1; e.iord = 1'b1;
                    for (int i = 0; i < mw; i++) cyc(e, 1'b0, "memwr_wait");
                    if (abort_mw) begin
                        mem_ready = 1'b1;
                        #1 rst_n = 1'b0;
                        m_ill = 1'b0;
                        #1 cmp(fetch_phase(1'b0), "async_reset_memwr");
                        mem_ready = 1'b0;
                        #1 rst_n = 1'b1;
                        @(posedge clk);
                        #1;
                    end else begin
                        cyc(e, 1'b1, "memwr");
                    end
                end
            end
            6'b000000: begin
                fok = 1'b1;
                case (fn)
                    6'b100000: aop = 3'b010;
                    6'b100010: aop = 3'b110;
                    6'b100100: aop = 3'b000;
                    6'b100101: aop = 3'b001;
                    6'b000000: aop = 3'b111;
                    default: begin aop = 3'b010; fok = 1'b0; end
                endcase
                e = quiet(4'd6); e.alu_src_a = 1'b1; e.alu_op = aop;
                cyc(e, rbit(), "rtex");
                if (fok) begin
                    e = quiet(4'd7); e.reg_write = 1'b1; e.reg_dst = 1'b1;
                    cyc(e, rbit(), "rtwb");
                end else begin
                    take_illegal("rt_illegal_halt");
                end
            end
            6'b000100: begin
                e = quiet(4'd8); e.alu_src_a = 1'b1; e.alu_op = 3'b110;
                e.pc_src = 2'b01; e.pc_en = z;
                cyc(e, rbit(), "beqex");
            end
            6'b001000: begin
                e = quiet(4'd9); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                cyc(e, rbit(), "addiex");
                e = quiet(4'd10); e.reg_write = 1'b1;
                cyc(e, rbit(), "addiwb");
            end
            6'b000010: begin
                e = quiet(4'd11); e.pc_src = 2'b10; e.pc_en = 1'b1;
                cyc(e, rbit(), "jex");
            end
            default: take_illegal("op_illegal_halt");
        endcase
    endtask

    task automatic reset_all();
        rst_n = 1'b0;
        m_ill = 1'b0;
        #1 cmp(fetch_phase(1'b0), "reset_async");
        @(posedge clk);
        #1 cmp(fetch_phase(1'b0), "reset_hold");
        rst_n = 1'b1;
    endtask

    logic [5:0] op_tab [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b001000, 6'b000010, 6'b111111, 6'b010101};
    logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b000000, 6'b101010};

    initial begin
        // Reset with mem_ready high: FETCH values, strobes suppressed.
        mem_ready = 1'b1;
        #2 cmp(fetch_phase(1'b0), "reset_before_clk");
        reset_all();

        // Directed: sub, lw with 3 wait states, beq taken/not, illegal op.
        instr(6'b000000, 6'b100010, 1'b0, 0, 0, 1'b0);
        instr(6'b100011, 6'b000000, 1'b0, 0, 3, 1'b0);
        instr(6'b000100, 6'b000000, 1'b1, 0, 0, 1'b0);
        instr(6'b000100, 6'b000000, 1'b0, 1, 0, 1'b0);
        instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
        instr(6'b001000, 6'b000000, 1'b0, 0, 0, 1'b0);

        // Random program on the flag-and-continue instance.
        for (int n = 0; n < 80; n++) begin
            instr(op_tab[$urandom_range(0, 7)], fn_tab[$urandom_range(0, 5)],
                  rbit(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        // Abandon a store mid-wait with an asynchronous reset pulse.
        instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
        instr(6'b101011, 6'b000000, 1'b0, 0, 2, 1'b1);
        instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1'b0);

        // Halting instance: legal traffic, then an illegal opcode parks it.
        halt_mode = 1'b1;
        reset_all();
        for (int n = 0; n < 20; n++) begin
            instr(op_tab[$urandom_range(0, 5)], fn_tab[$urandom_range(0, 4)],
                  rbit(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end
        instr(6'b111111, 6'b000000, 1'b0, 0, 0, 1'b0);
        reset_all();
        instr(6'b000000, 6'b101010, 1'b0, 0, 0, 1'b0);
        reset_all();
        instr(6'b100011, 6'b000000, 1'b0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
